// File: rtl/timer_capture_pkg.sv
// Shared definitions for the input-capture timer: edge-select encodings,
// default counter width and the edge-select decode.
package timer_capture_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int CNT_W_DEF = 16;

    function automatic logic edge_hit(input logic [1:0] sel, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/timer_capture_fifo.sv
// Show-ahead circular capture buffer; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module capture_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr_b,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    assign valid = (wr_q != rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;
    assign head  = valid ? mem_q[rd_q[AW-1:0]] : '0;

    // A pop frees the head slot, so a push into a full buffer succeeds in the same cycle.
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, do_push};
        rd_d = rd_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/timer_capture.sv
// Input-capture timer: free-running counter time-stamped on selected edges of an
// asynchronous event pin, with stamps queued for a valid/ready consumer.
module timer_capture
    import timer_capture_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     clr_b,
    input  logic                     en,
    input  logic [1:0]               edge_sel,
    input  logic                     evt_in,
    output logic [CNT_W-1:0]         cnt,
    output logic [CNT_W-1:0]         cap_data,
    output logic                     cap_valid,
    input  logic                     cap_ready,
    output logic [$clog2(DEPTH):0]   fifo_lvl,
    output logic                     ovf_flag,
    output logic                     lost_flag,
    input  logic                     flag_clr
);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   ovf_q, ovf_d;
    logic                   lost_q, lost_d;
    logic                   evt_s, rise, fall, hit, wrap, fifo_full, lost_set;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = evt_in;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign evt_s = sync_q[SYNC_STAGES-1];
    assign rise  = evt_s & ~prev_q;
    assign fall  = ~evt_s & prev_q;
    // History keeps tracking while disabled so re-enabling never reports a stale edge.
    assign hit   = en & edge_hit(edge_sel, rise, fall);
    assign wrap  = en & (&cnt_q);

    assign lost_set = hit & fifo_full & ~(cap_valid & cap_ready);

    always_comb begin
        prev_d = evt_s;
        cnt_d  = en ? cnt_q + CNT_W'(1) : cnt_q;
        ovf_d  = wrap | (ovf_q & ~flag_clr);
        lost_d = lost_set | (lost_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            cnt_q  <= '0;
            sync_q <= '0;
            prev_q <= 1'b0;
            ovf_q  <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
            lost_q <= lost_d;
        end
    end

    capture_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr_b     (clr_b),
        .push      (hit),
        .push_data (cnt_q),
        .pop       (cap_ready),
        .head      (cap_data),
        .valid     (cap_valid),
        .full      (fifo_full),
        .level     (fifo_lvl)
    );

    assign cnt       = cnt_q;
    assign ovf_flag  = ovf_q;
    assign lost_flag = lost_q;

endmodule

// File: tb/tb_timer_capture.sv
// Scoreboard bench for timer_capture: a 16-bit instance for capture/FIFO behaviour
// and a 4-bit instance sharing the same stimulus for counter wrap behaviour.
module tb_timer_capture;

    logic        clk;
    logic        clr_b;
    logic        en;
    logic [1:0]  edge_sel;
    logic        evt_in;
    logic        cap_ready;
    logic        flag_clr;

    logic [15:0] cnt, cap_data;
    logic        cap_valid, ovf_flag, lost_flag;
    logic [2:0]  fifo_lvl;

    logic [3:0]  cnt4, cap_data4;
    logic        cap_valid4, ovf4, lost4;
    logic [2:0]  fifo_lvl4;

    logic [15:0] m_cnt = '0;
    logic [15:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    timer_capture #(.CNT_W(16), .DEPTH(4), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .clr_b(clr_b), .en(en), .edge_sel(edge_sel), .evt_in(evt_in),
        .cnt(cnt), .cap_data(cap_data), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .fifo_lvl(fifo_lvl), .ovf_flag(ovf_flag), .lost_flag(lost_flag), .flag_clr(flag_clr)
    );

    timer_capture #(.CNT_W(4), .DEPTH(4), .SYNC_STAGES(2)) u_dut4 (
        .clk(clk), .clr_b(clr_b), .en(en), .edge_sel(edge_sel), .evt_in(evt_in),
        .cnt(cnt4), .cap_data(cap_data4), .cap_valid(cap_valid4), .cap_ready(cap_ready),
        .fifo_lvl(fifo_lvl4), .ovf_flag(ovf4), .lost_flag(lost4), .flag_clr(flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference counter for the 16-bit instance.
    always @(posedge clk or negedge clr_b) begin
        if (!clr_b)  m_cnt <= '0;
        else if (en) m_cnt <= m_cnt + 16'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input logic [15:0] t);
        int n;
        n = 0;
        while (m_cnt != t && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_cnt", cnt, t);
    endtask

    task automatic wait_cnt4(input logic [3:0] t);
        int n;
        n = 0;
        while (cnt4 != t && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_cnt4", cnt4, t);
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 16'd0;
        check_eq({tag, "_valid"}, cap_valid, 1);
        check_eq({tag, "_data"}, cap_data, e);
        cap_ready = 1'b1;
        step(1);
        cap_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] e;
        clr_b = 1'b0; en = 1'b1; edge_sel = 2'b01; evt_in = 1'b0;
        cap_ready = 1'b0; flag_clr = 1'b0;

        // 1: reset holds everything at zero while the pin toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            evt_in = ~evt_in;
        end
        step(1);
        check_eq("rst_cnt", cnt, 0);
        check_eq("rst_cap_data", cap_data, 0);
        check_eq("rst_cap_valid", cap_valid, 0);
        check_eq("rst_lvl", fifo_lvl, 0);
        check_eq("rst_ovf", ovf_flag, 0);
        check_eq("rst_lost", lost_flag, 0);
        check_eq("rst_cnt4", cnt4, 0);
        clr_b = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check_eq("cnt_after_rst", cnt, i);
        end

        // 2: rising capture, falling edge ignored
        wait_cnt(16'd10);
        evt_in = 1'b1;
        sb.push_back(m_cnt + 16'd2);
        step(4);
        check_eq("rise_lvl", fifo_lvl, 1);
        check_eq("rise_head", cap_data, sb[0]);
        evt_in = 1'b0;
        step(4);
        check_eq("fall_ignored_lvl", fifo_lvl, 1);
        pop_check("rise_pop");
        check_eq("empty_valid", cap_valid, 0);
        check_eq("empty_data", cap_data, 0);

        // 3: both edges, ordered drain
        edge_sel = 2'b11;
        wait_cnt(16'd20);
        evt_in = 1'b1;
        sb.push_back(m_cnt + 16'd2);
        wait_cnt(16'd30);
        evt_in = 1'b0;
        sb.push_back(m_cnt + 16'd2);
        step(4);
        check_eq("both_lvl", fifo_lvl, 2);
        pop_check("both_pop0");
        pop_check("both_pop1");

        // 4: overflow of the FIFO, then push+pop while full
        for (int k = 0; k < 5; k++) begin
            evt_in = ~evt_in;
            if (k < 4) sb.push_back(m_cnt + 16'd2);
            step(4);
        end
        check_eq("full_lvl", fifo_lvl, 4);
        check_eq("full_lost", lost_flag, 1);
        check_eq("full_head", cap_data, sb[0]);
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check_eq("lost_cleared", lost_flag, 0);
        evt_in = ~evt_in;
        e = m_cnt + 16'd2;
        step(2);
        pop_check("full_pushpop");
        sb.push_back(e);
        check_eq("pushpop_lvl", fifo_lvl, 4);
        check_eq("pushpop_lost", lost_flag, 0);
        for (int k = 0; k < 4; k++) pop_check("drain");
        check_eq("drain_lvl", fifo_lvl, 0);

        // 5: counter wrap and overflow flag on the 4-bit instance
        check_eq("cnt4_model", cnt4, m_cnt[3:0]);
        wait_cnt4(4'd3);
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check_eq("ovf4_cleared", ovf4, 0);
        wait_cnt4(4'd15);
        check_eq("ovf4_before_wrap", ovf4, 0);
        step(1);
        check_eq("cnt4_wrapped", cnt4, 0);
        check_eq("ovf4_set", ovf4, 1);
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check_eq("ovf4_clr", ovf4, 0);
        wait_cnt4(4'd15);
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check_eq("ovf4_set_beats_clr", ovf4, 1);
        check_eq("ovf16_clear", ovf_flag, 0);

        // 6: en gating, then asynchronous reset with entries queued
        en = 1'b0;
        evt_in = ~evt_in;
        step(5);
        check_eq("gated_lvl", fifo_lvl, 0);
        check_eq("gated_cnt", cnt, m_cnt);
        en = 1'b1;
        step(4);
        check_eq("reenable_lvl", fifo_lvl, 0);
        for (int k = 0; k < 3; k++) begin
            evt_in = ~evt_in;
            sb.push_back(m_cnt + 16'd2);
            step(4);
        end
        check_eq("pre_rst_lvl", fifo_lvl, 3);
        check_eq("pre_rst_head", cap_data, sb[0]);
        #2;
        clr_b = 1'b0;
        #1;
        check_eq("async_rst_lvl", fifo_lvl, 0);
        check_eq("async_rst_valid", cap_valid, 0);
        check_eq("async_rst_cnt", cnt, 0);
        check_eq("async_rst_data", cap_data, 0);
        sb.delete();
        evt_in = 1'b0;
        @(negedge clk);
        clr_b = 1'b1;
        step(2);
        check_eq("post_rst_cnt", cnt, m_cnt);
        check_eq("post_rst_lvl", fifo_lvl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
